// File: rtl/jk_pkg.sv
// Shared definitions for the JK bank arbiter: command encodings, FSM states,
// owner encodings, the granted-beat payload and the JK next-state function.
package jk_pkg;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_REQ0 = 2'b01;
  localparam logic [1:0] OWNER_REQ1 = 2'b10;

  // State encodings match the owner encodings so owner is a direct copy.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } state_e;

  // Payload of the beat selected by the arbiter (address carried separately).
  typedef struct packed {
    logic       all;
    logic [1:0] cmd;
  } jk_beat_t;

  function automatic logic jk_next(input logic q, input logic [1:0] cmd);
    logic r;
    r = q;
    case (cmd)
      JK_HOLD: r = q;
      JK_CLR:  r = 1'b0;
      JK_SET:  r = 1'b1;
      JK_TGL:  r = ~q;
      default: r = q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK storage cell with update enable.
// Ports: i_clk, i_rst (async, active-high), i_en (apply i_cmd this edge),
//        i_cmd ({j,k}), o_q (cell state).
module jk_cell
  import jk_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [1:0] i_cmd,
  output logic       o_q
);

  logic r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q <= 1'b0;
    end else if (i_en) begin
      r_q <= jk_next(r_q, i_cmd);
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/jk_bank_arbiter.sv
// Bank of WIDTH JK cells shared by two valid/ready requesters through a
// round-robin arbiter with burst locking and a MAX_LOCK ownership timeout.
// Ports: clk, rst (async, active-high); per requester N: reqN_valid,
//        reqN_ready (combinational), reqN_addr, reqN_all, reqN_cmd, reqN_lock;
//        q (cell states), owner (00 none / 01 req0 / 10 req1),
//        lock_expired (one-cycle pulse after a forced release).
module jk_bank_arbiter
  import jk_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned MAX_LOCK = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic              req0_all,
  input  logic [1:0]        req0_cmd,
  input  logic              req0_lock,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic              req1_all,
  input  logic [1:0]        req1_cmd,
  input  logic              req1_lock,
  output logic [WIDTH-1:0]  q,
  output logic [1:0]        owner,
  output logic              lock_expired
);

  localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic               r_rr_ptr;
  logic               w_rr_ptr_nxt;
  logic               r_lock_expired;
  logic               w_lock_expired_nxt;
  logic [CNT_W-1:0]   r_lock_cnt;
  logic               w_lock_hit;
  logic               w_rdy0;
  logic               w_rdy1;
  logic               w_accept;
  logic [ADDR_W-1:0]  w_addr;
  jk_beat_t           w_beat;
  logic [WIDTH-1:0]   w_q;

  assign w_lock_hit = (r_lock_cnt == CNT_W'(MAX_LOCK));

  // State register, round-robin pointer and expiry pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_rr_ptr       <= 1'b0;
      r_lock_expired <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_rr_ptr       <= w_rr_ptr_nxt;
      r_lock_expired <= w_lock_expired_nxt;
    end
  end

  // Arbitration, next state and grants.
  always_comb begin
    w_state_nxt        = r_state;
    w_rr_ptr_nxt       = r_rr_ptr;
    w_lock_expired_nxt = 1'b0;
    w_rdy0             = 1'b0;
    w_rdy1             = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req0_valid && (!req1_valid || !r_rr_ptr)) begin
          w_rdy0 = 1'b1;
        end else if (req1_valid) begin
          w_rdy1 = 1'b1;
        end
        if (w_rdy0) begin
          w_rr_ptr_nxt = 1'b1;
          if (req0_lock) w_state_nxt = ST_OWN0;
        end else if (w_rdy1) begin
          w_rr_ptr_nxt = 1'b0;
          if (req1_lock) w_state_nxt = ST_OWN1;
        end
      end
      ST_OWN0: begin
        // Timeout wins over any owner beat offered in the same cycle.
        if (w_lock_hit) begin
          w_state_nxt        = ST_IDLE;
          w_lock_expired_nxt = 1'b1;
          w_rr_ptr_nxt       = 1'b1;
        end else begin
          w_rdy0 = req0_valid;
          if (w_rdy0 && !req0_lock) w_state_nxt = ST_IDLE;
        end
      end
      ST_OWN1: begin
        if (w_lock_hit) begin
          w_state_nxt        = ST_IDLE;
          w_lock_expired_nxt = 1'b1;
          w_rr_ptr_nxt       = 1'b0;
        end else begin
          w_rdy1 = req1_valid;
          if (w_rdy1 && !req1_lock) w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Grants are suppressed for as long as reset is asserted.
    if (rst) begin
      w_rdy0 = 1'b0;
      w_rdy1 = 1'b0;
    end
  end

  // Ownership age: zero in IDLE and on entry, counts every owned cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lock_cnt <= '0;
    end else if (r_state == ST_IDLE || w_state_nxt == ST_IDLE) begin
      r_lock_cnt <= '0;
    end else begin
      r_lock_cnt <= r_lock_cnt + CNT_W'(1);
    end
  end

  // Granted beat mux; at most one ready is ever high.
  assign w_accept   = w_rdy0 | w_rdy1;
  assign w_addr     = w_rdy1 ? req1_addr : req0_addr;
  assign w_beat.all = w_rdy1 ? req1_all  : req0_all;
  assign w_beat.cmd = w_rdy1 ? req1_cmd  : req0_cmd;

  // Addresses >= WIDTH match no cell, so such beats are accepted but inert.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic w_en;
    assign w_en = w_accept && (w_beat.all || (w_addr == ADDR_W'(i)));
    jk_cell u_cell (
      .i_clk (clk),
      .i_rst (rst),
      .i_en  (w_en),
      .i_cmd (w_beat.cmd),
      .o_q   (w_q[i])
    );
  end

  assign req0_ready   = w_rdy0;
  assign req1_ready   = w_rdy1;
  assign q            = w_q;
  assign owner        = 2'(r_state);
  assign lock_expired = r_lock_expired;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed self-checking bench for jk_bank_arbiter (WIDTH=8, MAX_LOCK=4).
module tb_jk_bank_arbiter;
  import jk_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req0_all = 1'b0, req0_lock = 1'b0;
  logic       req1_valid = 1'b0, req1_all = 1'b0, req1_lock = 1'b0;
  logic [2:0] req0_addr = '0, req1_addr = '0;
  logic [1:0] req0_cmd = '0, req1_cmd = '0;
  logic       req0_ready, req1_ready, lock_expired;
  logic [7:0] q;
  logic [1:0] owner;

  int errors = 0;
  int checks = 0;

  jk_bank_arbiter #(.WIDTH(8), .ADDR_W(3), .MAX_LOCK(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req0_all(req0_all), .req0_cmd(req0_cmd), .req0_lock(req0_lock),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_all(req1_all), .req1_cmd(req1_cmd), .req1_lock(req1_lock),
    .q(q), .owner(owner), .lock_expired(lock_expired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [2:0] a, input logic all,
                      input logic [1:0] c, input logic l);
    req0_valid = v; req0_addr = a; req0_all = all; req0_cmd = c; req0_lock = l;
  endtask

  task automatic set1(input logic v, input logic [2:0] a, input logic all,
                      input logic [1:0] c, input logic l);
    req1_valid = v; req1_addr = a; req1_all = all; req1_cmd = c; req1_lock = l;
  endtask

  // Single unlocked beat from one requester while the other is quiet.
  task automatic beat(input int port, input logic [2:0] a, input logic all,
                      input logic [1:0] c);
    if (port == 0) set0(1'b1, a, all, c, 1'b0);
    else           set1(1'b1, a, all, c, 1'b0);
    #1;
    chk("beat_rdy", 64'(port == 0 ? req0_ready : req1_ready), 64'(1));
    tick();
    set0(1'b0, 3'd0, 1'b0, JK_HOLD, 1'b0);
    set1(1'b0, 3'd0, 1'b0, JK_HOLD, 1'b0);
  endtask

  initial begin
    // Reset holds everything off even with a valid request pending.
    req0_valid = 1'b1;
    #2;
    chk("rst_q", 64'(q), 64'(8'h00));
    chk("rst_owner", 64'(owner), 64'(OWNER_NONE));
    chk("rst_exp", 64'(lock_expired), 64'(0));
    chk("rst_rdy0", 64'(req0_ready), 64'(0));
    tick();
    rst = 1'b0;

    // Single set on addr 2.
    set0(1'b1, 3'd2, 1'b0, JK_SET, 1'b0);
    #1;
    chk("s1_rdy0", 64'(req0_ready), 64'(1));
    chk("s1_rdy1", 64'(req1_ready), 64'(0));
    tick();
    chk("s1_q", 64'(q), 64'(8'h04));

    // Reset pulse between edges, then ties alternate 0,1,0,1.
    set0(1'b0, 3'd0, 1'b0, JK_HOLD, 1'b0);
    rst = 1'b1; #1; rst = 1'b0;
    chk("rp_q", 64'(q), 64'(8'h00));
    set0(1'b1, 3'd0, 1'b0, JK_SET, 1'b0);
    set1(1'b1, 3'd1, 1'b0, JK_SET, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("tie_rdy0", 64'(req0_ready), 64'((i % 2) == 0));
      chk("tie_rdy1", 64'(req1_ready), 64'((i % 2) == 1));
      tick();
      if (i == 0) chk("tie_q1", 64'(q), 64'(8'h01));
      if (i == 1) chk("tie_q2", 64'(q), 64'(8'h03));
    end

    // req1 locked burst of three toggles on addr 5; req0 shut out.
    set0(1'b0, 3'd0, 1'b0, JK_HOLD, 1'b0);
    set1(1'b1, 3'd5, 1'b0, JK_TGL, 1'b1);
    #1;
    chk("b_rdy1_a", 64'(req1_ready), 64'(1));
    tick();
    chk("b_own_a", 64'(owner), 64'(OWNER_REQ1));
    set0(1'b1, 3'd0, 1'b0, JK_HOLD, 1'b0);
    #1;
    chk("b_rdy0_b", 64'(req0_ready), 64'(0));
    chk("b_rdy1_b", 64'(req1_ready), 64'(1));
    tick();
    chk("b_own_b", 64'(owner), 64'(OWNER_REQ1));
    set1(1'b1, 3'd5, 1'b0, JK_TGL, 1'b0);
    #1;
    chk("b_rdy0_c", 64'(req0_ready), 64'(0));
    chk("b_rdy1_c", 64'(req1_ready), 64'(1));
    tick();
    chk("b_own_c", 64'(owner), 64'(OWNER_NONE));
    chk("b_q", 64'(q), 64'(8'h23));
    set1(1'b0, 3'd0, 1'b0, JK_HOLD, 1'b0);
    #1;
    chk("b_rdy0_d", 64'(req0_ready), 64'(1));
    tick();

    // req0 locks then goes quiet; timeout after lock_cnt reaches 4.
    set0(1'b1, 3'd0, 1'b0, JK_HOLD, 1'b1);
    #1;
    chk("to_rdy0", 64'(req0_ready), 64'(1));
    tick();
    set0(1'b0, 3'd0, 1'b0, JK_HOLD, 1'b0);
    set1(1'b1, 3'd0, 1'b0, JK_HOLD, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) set0(1'b1, 3'd0, 1'b0, JK_HOLD, 1'b0);
      #1;
      chk("to_own", 64'(owner), 64'(OWNER_REQ0));
      chk("to_rdy1", 64'(req1_ready), 64'(0));
      chk("to_exp", 64'(lock_expired), 64'(0));
      if (i == 4) chk("to_rdy0_hit", 64'(req0_ready), 64'(0));
      tick();
    end
    #1;
    chk("rel_own", 64'(owner), 64'(OWNER_NONE));
    chk("rel_exp", 64'(lock_expired), 64'(1));
    chk("rel_rdy1", 64'(req1_ready), 64'(1));
    chk("rel_rdy0", 64'(req0_ready), 64'(0));
    tick();
    chk("rel_exp_off", 64'(lock_expired), 64'(0));
    set0(1'b0, 3'd0, 1'b0, JK_HOLD, 1'b0);
    set1(1'b0, 3'd0, 1'b0, JK_HOLD, 1'b0);

    // Whole-bank commands.
    beat(1, 3'd0, 1'b1, JK_CLR);
    beat(0, 3'd0, 1'b0, JK_SET);
    beat(0, 3'd2, 1'b0, JK_SET);
    beat(0, 3'd5, 1'b0, JK_SET);
    beat(0, 3'd7, 1'b0, JK_SET);
    chk("all_a5", 64'(q), 64'(8'hA5));
    beat(1, 3'd3, 1'b1, JK_TGL);
    chk("all_5a", 64'(q), 64'(8'h5A));
    beat(1, 3'd3, 1'b1, JK_CLR);
    chk("all_00", 64'(q), 64'(8'h00));

    // Async reset in the middle of a req1 burst.
    beat(0, 3'd0, 1'b1, JK_SET);
    chk("mr_ff", 64'(q), 64'(8'hFF));
    set1(1'b1, 3'd0, 1'b0, JK_HOLD, 1'b1);
    tick();
    set0(1'b1, 3'd1, 1'b0, JK_TGL, 1'b0);
    #1;
    chk("mr_own", 64'(owner), 64'(OWNER_REQ1));
    chk("mr_rdy0", 64'(req0_ready), 64'(0));
    #1;
    rst = 1'b1;
    #1;
    chk("mr_q", 64'(q), 64'(8'h00));
    chk("mr_own_rst", 64'(owner), 64'(OWNER_NONE));
    chk("mr_rdy0_rst", 64'(req0_ready), 64'(0));
    chk("mr_rdy1_rst", 64'(req1_ready), 64'(0));
    tick();
    rst = 1'b0;
    set0(1'b1, 3'd1, 1'b0, JK_SET, 1'b0);
    set1(1'b1, 3'd3, 1'b0, JK_SET, 1'b0);
    #1;
    chk("mr_tie_rdy0", 64'(req0_ready), 64'(1));
    chk("mr_tie_rdy1", 64'(req1_ready), 64'(0));
    tick();
    chk("mr_tie_q", 64'(q), 64'(8'h02));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
